video_mono_filter: RTL and testbench

- Pipelined, parametrised successor to the top-level combinational colour/monochrome output mux.
- Sits between the system VGA RGB/sync/blank outputs and the board VGA pins.
- Computes BT.709 luma arithmetically instead of using lookup ROMs, and adds two further tint modes plus optional scanline dimming.
- Latches mode changes only at frame boundaries and delays sync/blank to stay aligned with pixels.

---
 rtl/video_pkg.sv | 19 +
 rtl/video_mono_filter_luma.sv | 58 +++++
 rtl/video_mono_filter.sv | 125 ++++++++++++
 tb/tb_video_mono_filter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the monochrome/tint video output filter.
package video_pkg;

  typedef enum logic [2:0] {
    MODE_COLOR   = 3'd0,
    MODE_GREEN   = 3'd1,
    MODE_AMBER   = 3'd2,
    MODE_WHITE   = 3'd3,
    MODE_INVERSE = 3'd4
  } mono_mode_t;

  localparam int PIPE_LAT = 3;

  // BT.709 luma weights in 1/256 units; they sum to 256.
  localparam int DEF_KR = 54;
  localparam int DEF_KG = 183;
  localparam int DEF_KB = 19;

endpackage

// File: rtl/video_mono_filter_luma.sv
// Two-stage luma calculator: weighted products, then summed and saturated Y,
// with an opaque sideband bus delayed alongside.
module luma_calc
  import video_pkg::*;
#(
  parameter int CW = 6,
  parameter int KR = DEF_KR,
  parameter int KG = DEF_KG,
  parameter int KB = DEF_KB,
  parameter int SW = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CW-1:0] r,
  input  logic [CW-1:0] g,
  input  logic [CW-1:0] b,
  input  logic [SW-1:0] side_in,
  output logic [CW-1:0] y,
  output logic [SW-1:0] side_out
);

  localparam int PW   = CW + 8;
  localparam int SUMW = CW + 10;
  localparam logic [PW-1:0] WR = PW'(KR);
  localparam logic [PW-1:0] WG = PW'(KG);
  localparam logic [PW-1:0] WB = PW'(KB);
  localparam logic [CW-1:0] YMAX = '1;

  logic [PW-1:0]   pr, pg, pb;
  logic [SW-1:0]   side_s1;
  logic [SUMW-1:0] sum;
  logic [CW+1:0]   y_wide;

  // Two guard bits above CW let a non-default weight set overflow visibly.
  always_comb begin
    sum    = SUMW'(pr) + SUMW'(pg) + SUMW'(pb);
    y_wide = (CW+2)'(sum >> 8);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pr       <= '0;
      pg       <= '0;
      pb       <= '0;
      side_s1  <= '0;
      y        <= '0;
      side_out <= '0;
    end else begin
      pr       <= WR * PW'(r);
      pg       <= WG * PW'(g);
      pb       <= WB * PW'(b);
      side_s1  <= side_in;
      y        <= (y_wide > (CW+2)'(YMAX)) ? YMAX : y_wide[CW-1:0];
      side_out <= side_s1;
    end
  end

endmodule

// File: rtl/video_mono_filter.sv
// VGA output filter: colour / green / amber / white / inverse tint modes,
// frame-latched mode select, odd-line dimming, 3-cycle aligned pipeline.
module video_mono_filter
  import video_pkg::*;
#(
  parameter int CW = 6,
  parameter int KR = DEF_KR,
  parameter int KG = DEF_KG,
  parameter int KB = DEF_KB
) (
  input  logic          clk_vga,
  input  logic          reset_n,
  input  logic [2:0]    mode,
  input  logic          scanline_en,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          hb_in,
  input  logic          vb_in,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          hb_out,
  output logic          vb_out,
  output logic [2:0]    mode_act
);

  localparam int SW = 3*CW + 5;
  localparam logic [CW-1:0] VMAX = '1;

  logic          vb_prev, hb_prev, parity;
  logic          vb_rise, hb_rise;
  logic [SW-1:0] side_in, side_s2;
  logic [CW-1:0] y_s2, r_s2, g_s2, b_s2;
  logic          hs_s2, vs_s2, hb_s2, vb_s2, par_s2;
  logic [CW-1:0] r_mix, g_mix, b_mix;
  mono_mode_t    mode_sel;

  assign vb_rise  = vb_in & ~vb_prev;
  assign hb_rise  = hb_in & ~hb_prev;
  // Parity rides with the pixel so dimming follows the pixel's own line.
  assign side_in  = {r_in, g_in, b_in, hs_in, vs_in, hb_in, vb_in, parity};
  assign {r_s2, g_s2, b_s2, hs_s2, vs_s2, hb_s2, vb_s2, par_s2} = side_s2;
  assign mode_sel = mono_mode_t'(mode_act);

  luma_calc #(
    .CW(CW),
    .KR(KR),
    .KG(KG),
    .KB(KB),
    .SW(SW)
  ) u_luma (
    .clk     (clk_vga),
    .reset_n (reset_n),
    .r       (r_in),
    .g       (g_in),
    .b       (b_in),
    .side_in (side_in),
    .y       (y_s2),
    .side_out(side_s2)
  );

  function automatic logic [CW-1:0] dim(input logic [CW-1:0] v);
    return v - (v >> 2);
  endfunction

  // Undefined mode codes 5-7 fall through to raw colour.
  always_comb begin
    r_mix = r_s2;
    g_mix = g_s2;
    b_mix = b_s2;
    case (mode_sel)
      MODE_GREEN:   begin r_mix = '0;          g_mix = y_s2;        b_mix = '0;          end
      MODE_AMBER:   begin r_mix = y_s2;        g_mix = y_s2 >> 1;   b_mix = '0;          end
      MODE_WHITE:   begin r_mix = y_s2;        g_mix = y_s2;        b_mix = y_s2;        end
      MODE_INVERSE: begin r_mix = VMAX - y_s2; g_mix = VMAX - y_s2; b_mix = VMAX - y_s2; end
      default: ;
    endcase
    if (scanline_en && par_s2) begin
      r_mix = dim(r_mix);
      g_mix = dim(g_mix);
      b_mix = dim(b_mix);
    end
    if (hb_s2 || vb_s2) begin
      r_mix = '0;
      g_mix = '0;
      b_mix = '0;
    end
  end

  // Vertical-blank rise both latches the mode and restarts line parity.
  always_ff @(posedge clk_vga) begin
    if (!reset_n) begin
      r_out    <= '0;
      g_out    <= '0;
      b_out    <= '0;
      hs_out   <= 1'b0;
      vs_out   <= 1'b0;
      hb_out   <= 1'b0;
      vb_out   <= 1'b0;
      mode_act <= 3'd0;
      parity   <= 1'b0;
      vb_prev  <= 1'b0;
      hb_prev  <= 1'b0;
    end else begin
      r_out    <= r_mix;
      g_out    <= g_mix;
      b_out    <= b_mix;
      hs_out   <= hs_s2;
      vs_out   <= vs_s2;
      hb_out   <= hb_s2;
      vb_out   <= vb_s2;
      vb_prev  <= vb_in;
      hb_prev  <= hb_in;
      if (vb_rise) mode_act <= mode;
      if (vb_rise) parity <= 1'b0;
      else if (hb_rise) parity <= ~parity;
    end
  end

endmodule

// File: tb/tb_video_mono_filter.sv
// Self-checking bench for video_mono_filter: directed scenarios with fixed
// expected pixels plus a randomised run against a frame-level reference model.
module tb_video_mono_filter;
  import video_pkg::*;

  localparam int CW   = 6;
  localparam int MAXV = (1 << CW) - 1;
  localparam int VW   = 3*CW + 7;

  logic          clk_vga = 1'b0;
  logic          reset_n;
  logic [2:0]    mode;
  logic          scanline_en;
  logic [CW-1:0] r_in, g_in, b_in;
  logic          hs_in, vs_in, hb_in, vb_in;
  logic [CW-1:0] r_out, g_out, b_out;
  logic          hs_out, vs_out, hb_out, vb_out;
  logic [2:0]    mode_act;

  video_mono_filter #(.CW(CW)) dut (
    .clk_vga    (clk_vga),
    .reset_n    (reset_n),
    .mode       (mode),
    .scanline_en(scanline_en),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .hb_in      (hb_in),
    .vb_in      (vb_in),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .hb_out     (hb_out),
    .vb_out     (vb_out),
    .mode_act   (mode_act)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct {
    int r, g, b;
    bit hs, vs, hb, vb, par;
  } pix_t;

  pix_t          pipe[$];
  int            m_mode;
  bit            m_par, m_vbp, m_hbp;
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] obs_vec;
  int            checks   = 0;
  int            failures = 0;

  assign obs_vec = {r_out, g_out, b_out, hs_out, vs_out, hb_out, vb_out, mode_act};

  function automatic pix_t zero_pix();
    pix_t z;
    z.r = 0; z.g = 0; z.b = 0;
    z.hs = 0; z.vs = 0; z.hb = 0; z.vb = 0; z.par = 0;
    return z;
  endfunction

  // What the pixel should look like on the pins, from the mode rules alone.
  function automatic pix_t render(pix_t p, int md, bit scan);
    pix_t o;
    int   y;
    o = p;
    y = (DEF_KR*p.r + DEF_KG*p.g + DEF_KB*p.b) / 256;
    if (y > MAXV) y = MAXV;
    case (md)
      1: begin o.r = 0; o.g = y;     o.b = 0; end
      2: begin o.r = y; o.g = y / 2; o.b = 0; end
      3: begin o.r = y; o.g = y;     o.b = y; end
      4: begin o.r = MAXV - y; o.g = MAXV - y; o.b = MAXV - y; end
      default: ;
    endcase
    if (scan && p.par) begin
      o.r = o.r - o.r / 4;
      o.g = o.g - o.g / 4;
      o.b = o.b - o.b / 4;
    end
    if (p.hb || p.vb) begin
      o.r = 0; o.g = 0; o.b = 0;
    end
    return o;
  endfunction

  task automatic applyStimulus(input int r, input int g, input int b,
                               input bit hs, input bit vs, input bit hb, input bit vb);
    r_in  = CW'(r);
    g_in  = CW'(g);
    b_in  = CW'(b);
    hs_in = hs;
    vs_in = vs;
    hb_in = hb;
    vb_in = vb;
  endtask

  // One clock: update the reference model from the sampled inputs, then settle.
  task automatic step();
    pix_t o, nw;
    bit   vr, hr;
    @(posedge clk_vga);
    if (!reset_n) begin
      pipe.delete();
      pipe.push_back(zero_pix());
      pipe.push_back(zero_pix());
      o = zero_pix();
      m_mode = 0; m_par = 0; m_vbp = 0; m_hbp = 0;
    end else begin
      o = render(pipe[1], m_mode, scanline_en);
      nw.r = int'(r_in); nw.g = int'(g_in); nw.b = int'(b_in);
      nw.hs = hs_in; nw.vs = vs_in; nw.hb = hb_in; nw.vb = vb_in; nw.par = m_par;
      void'(pipe.pop_back());
      pipe.push_front(nw);
      vr = vb_in && !m_vbp;
      hr = hb_in && !m_hbp;
      if (vr) m_mode = int'(mode);
      if (vr) m_par = 0;
      else if (hr) m_par = !m_par;
      m_vbp = vb_in;
      m_hbp = hb_in;
    end
    exp_vec = {o.r[CW-1:0], o.g[CW-1:0], o.b[CW-1:0], o.hs, o.vs, o.hb, o.vb, m_mode[2:0]};
    #1;
  endtask

  task automatic pulse_vb(input int m);
    mode = 3'(m);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mode    = 3'd3;
    applyStimulus(5, 6, 7, 1, 1, 0, 0);
    repeat (2) begin
      step();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL reset_model got=%h exp=%h", obs_vec, exp_vec);
      end
    end
    checks++;
    if (obs_vec !== '0) begin
      failures++;
      $display("[TB] FAIL reset_zero got=%h exp=0", obs_vec);
    end
    reset_n = 1'b1;
    mode    = 3'd0;
  endtask

  task automatic test_color_latency();
    applyStimulus(10, 20, 30, 1, 1, 0, 0);
    for (int i = 1; i <= PIPE_LAT; i++) begin
      step();
      if (i == 1) applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL color_model step=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i == PIPE_LAT - 1) begin
        checks++;
        if ({r_out, hs_out, vs_out} !== {6'd0, 1'b0, 1'b0}) begin
          failures++;
          $display("[TB] FAIL color_early r=%0d hs=%b vs=%b exp 0/0/0", r_out, hs_out, vs_out);
        end
      end
    end
    checks++;
    if ({r_out, g_out, b_out, hs_out, vs_out} !== {6'd10, 6'd20, 6'd30, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL color_lat3 got=%0d,%0d,%0d hs=%b vs=%b exp 10,20,30 hs=1 vs=1",
               r_out, g_out, b_out, hs_out, vs_out);
    end
  endtask

  task automatic test_green();
    pulse_vb(1);
    applyStimulus(63, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (PIPE_LAT - 1) begin
      step();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL green_model got=%h exp=%h", obs_vec, exp_vec);
      end
    end
    checks++;
    if ({r_out, g_out, b_out, mode_act} !== {6'd0, 6'd13, 6'd0, 3'd1}) begin
      failures++;
      $display("[TB] FAIL green_pix got=%0d,%0d,%0d mode=%0d exp 0,13,0 mode=1",
               r_out, g_out, b_out, mode_act);
    end
  endtask

  task automatic test_tints();
    int rr[3] = '{0, 63, 0};
    int gg[3] = '{63, 63, 0};
    int bb[3] = '{0, 63, 0};
    logic [3*CW-1:0] want[3];
    want[0] = {6'd45, 6'd22, 6'd0};
    want[1] = {6'd63, 6'd63, 6'd63};
    want[2] = {6'd63, 6'd63, 6'd63};
    for (int t = 0; t < 3; t++) begin
      pulse_vb(t + 2);
      applyStimulus(rr[t], gg[t], bb[t], 0, 0, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (PIPE_LAT - 1) begin
        step();
        checks++;
        if (obs_vec !== exp_vec) begin
          failures++;
          $display("[TB] FAIL tint_model mode=%0d got=%h exp=%h", t + 2, obs_vec, exp_vec);
        end
      end
      checks++;
      if ({r_out, g_out, b_out} !== want[t]) begin
        failures++;
        $display("[TB] FAIL tint_pix mode=%0d got=%0d,%0d,%0d exp=%h",
                 t + 2, r_out, g_out, b_out, want[t]);
      end
    end
  endtask

  task automatic test_mode_midframe();
    pulse_vb(3);
    mode = 3'd1;
    applyStimulus(63, 63, 63, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL midframe_model step=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i >= PIPE_LAT) begin
        checks++;
        if ({r_out, g_out, b_out, mode_act} !== {6'd63, 6'd63, 6'd63, 3'd3}) begin
          failures++;
          $display("[TB] FAIL midframe_hold got=%0d,%0d,%0d mode=%0d exp 63,63,63 mode=3",
                   r_out, g_out, b_out, mode_act);
        end
      end
    end
    pulse_vb(1);
    applyStimulus(63, 63, 63, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (PIPE_LAT - 1) step();
    checks++;
    if ({r_out, g_out, b_out, mode_act} !== {6'd0, 6'd63, 6'd0, 3'd1}) begin
      failures++;
      $display("[TB] FAIL midframe_switch got=%0d,%0d,%0d mode=%0d exp 0,63,0 mode=1",
               r_out, g_out, b_out, mode_act);
    end
  endtask

  task automatic test_scanline();
    int want[3] = '{63, 48, 63};
    pulse_vb(3);
    scanline_en = 1'b1;
    for (int ln = 0; ln < 3; ln++) begin
      if (ln == 1) begin
        applyStimulus(63, 63, 63, 0, 0, 1, 0);
        step();
      end
      if (ln == 2) pulse_vb(3);
      applyStimulus(63, 63, 63, 0, 0, 0, 0);
      for (int i = 1; i <= PIPE_LAT; i++) begin
        step();
        checks++;
        if (obs_vec !== exp_vec) begin
          failures++;
          $display("[TB] FAIL scan_model line=%0d got=%h exp=%h", ln, obs_vec, exp_vec);
        end
      end
      checks++;
      if ({r_out, g_out, b_out} !== {3{CW'(want[ln])}}) begin
        failures++;
        $display("[TB] FAIL scan_pix line=%0d got=%0d,%0d,%0d exp %0d",
                 ln, r_out, g_out, b_out, want[ln]);
      end
    end
    scanline_en = 1'b0;
  endtask

  task automatic test_reset_midline();
    pulse_vb(2);
    applyStimulus(63, 40, 20, 1, 0, 0, 0);
    repeat (4) step();
    reset_n = 1'b0;
    step();
    checks++;
    if (obs_vec !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_zero got=%h exp=0", obs_vec);
    end
    reset_n = 1'b1;
    applyStimulus(10, 20, 30, 1, 0, 0, 0);
    for (int i = 1; i <= PIPE_LAT; i++) begin
      step();
      if (i == 1) applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL midreset_model step=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if ({r_out, g_out, b_out, hs_out, mode_act} !== {6'd10, 6'd20, 6'd30, 1'b1, 3'd0}) begin
      failures++;
      $display("[TB] FAIL midreset_resume got=%0d,%0d,%0d hs=%b mode=%0d exp 10,20,30 hs=1 mode=0",
               r_out, g_out, b_out, hs_out, mode_act);
    end
  endtask

  task automatic test_random();
    bit hb, vb;
    hb = 0;
    vb = 0;
    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 15) == 0) mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 40) == 0) scanline_en = ~scanline_en;
      if ($urandom_range(0, 6) == 0) hb = ~hb;
      if ($urandom_range(0, 60) == 0) vb = ~vb;
      applyStimulus($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV),
                    1'($urandom), 1'($urandom), hb, vb);
      step();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL random cycle=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    pipe.push_back(zero_pix());
    pipe.push_back(zero_pix());
    m_mode      = 0;
    m_par       = 0;
    m_vbp       = 0;
    m_hbp       = 0;
    exp_vec     = '0;
    reset_n     = 1'b0;
    mode        = 3'd0;
    scanline_en = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_color_latency();
    test_green();
    test_tints();
    test_mode_midframe();
    test_scanline();
    test_reset_midline();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
